// File: rtl/hanoi_solver.sv
// Iterative Tower of Hanoi move generator: emits one legal move per accepted handshake
// and tracks peg occupancy, flagging any move that would break the stacking rule.
module hanoi_solver #(
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         mv_valid,
  input  logic         mv_ready,
  output logic [1:0]   mv_fr,
  output logic [1:0]   mv_to,
  output logic [3:0]   mv_disk,
  output logic [S-1:0] mv_idx,
  output logic [S-1:0] peg0,
  output logic [S-1:0] peg1,
  output logic [S-1:0] peg2,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [1:0] fr;
    logic [1:0] to;
    logic [3:0] disk;
  } mv_t;

  localparam logic [S-1:0] LAST = '1;

  // Bit-serial residue mod 3, MSB first; avoids a generic divider.
  function automatic logic [1:0] mod3(input logic [S:0] v);
    logic [2:0] t;
    logic [1:0] r;
    r = '0;
    for (int i = S; i >= 0; i--) begin
      t = {r, v[i]};
      if (t >= 3'd3) t = t - 3'd3;
      r = t[1:0];
    end
    return r;
  endfunction

  function automatic mv_t calc(input logic [S-1:0] m);
    logic [S:0] w, wm1;
    logic [1:0] a, b;
    mv_t r;
    w   = {1'b0, m};
    wm1 = w - 1'b1;
    a   = mod3(w & wm1);
    b   = mod3((w | wm1) + 1'b1);
    // Even towers swap pegs 1/2 so the stack always lands on peg 2.
    if (S % 2 == 0) begin
      a = (a == 2'd1) ? 2'd2 : (a == 2'd2) ? 2'd1 : a;
      b = (b == 2'd1) ? 2'd2 : (b == 2'd2) ? 2'd1 : b;
    end
    r.disk = '0;
    for (int i = S - 1; i >= 0; i--)
      if (m[i]) r.disk = 4'(i + 1);
    r.fr = a;
    r.to = b;
    return r;
  endfunction

  state_t     state, nstate;
  mv_t        mv;
  logic [S-1:0] dmask, below, src, dst, n0, n1, n2;
  logic       last, bad;

  assign mv_fr    = mv.fr;
  assign mv_to    = mv.to;
  assign mv_disk  = mv.disk;
  assign mv_valid = (state == OFFER);
  assign busy     = (state == OFFER);
  assign done     = (state == DONE);
  assign last     = (mv_idx == LAST);

  always_comb begin
    dmask = '0;
    below = '0;
    for (int i = 0; i < S; i++) begin
      dmask[i] = (mv.disk == 4'(i + 1));
      below[i] = (4'(i + 1) < mv.disk);
    end
    case (mv.fr)
      2'd0:    src = peg0;
      2'd1:    src = peg1;
      default: src = peg2;
    endcase
    case (mv.to)
      2'd0:    dst = peg0;
      2'd1:    dst = peg1;
      default: dst = peg2;
    endcase
    bad = ~|(src & dmask) | (|(dst & below));
    n0  = (peg0 & ~((mv.fr == 2'd0) ? dmask : '0)) | ((mv.to == 2'd0) ? dmask : '0);
    n1  = (peg1 & ~((mv.fr == 2'd1) ? dmask : '0)) | ((mv.to == 2'd1) ? dmask : '0);
    n2  = (peg2 & ~((mv.fr == 2'd2) ? dmask : '0)) | ((mv.to == 2'd2) ? dmask : '0);
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE, DONE: if (start) nstate = OFFER;
      OFFER:      if (mv_ready && last) nstate = DONE;
      default:    nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv     <= '0;
      mv_idx <= '0;
      peg0   <= '1;
      peg1   <= '0;
      peg2   <= '0;
      err    <= 1'b0;
    end else if (state != OFFER) begin
      if (start) begin
        mv     <= calc(S'(1));
        mv_idx <= S'(1);
        peg0   <= '1;
        peg1   <= '0;
        peg2   <= '0;
        err    <= 1'b0;
      end
    end else if (mv_ready) begin
      peg0 <= n0;
      peg1 <= n1;
      peg2 <= n2;
      if (bad) err <= 1'b1;
      if (!last) begin
        mv_idx <= mv_idx + 1'b1;
        mv     <= calc(mv_idx + 1'b1);
      end
    end
  end

endmodule
